// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, condition codes and the NZCV flag record.
package exec_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_ADD = 4'h1,
    ALU_SUB = 4'h2,
    ALU_ORR = 4'h3,
    ALU_EOR = 4'h4,
    ALU_LSL = 4'h5,
    ALU_LSR = 4'h6,
    ALU_ASR = 4'h7,
    ALU_SLT = 4'h8,
    ALU_MOV = 4'h9,
    ALU_MVN = 4'hA,
    ALU_BIC = 4'hB,
    ALU_RSB = 4'hC
  } alu_op_e;

  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_GE = 3'd3,
    COND_LT = 3'd4,
    COND_GT = 3'd5,
    COND_LE = 3'd6,
    COND_CS = 3'd7
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/exec_pau.sv
// Packed-pixel unit: independent unsigned saturating add/sub on each 8-bit lane.
module exec_pau
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  localparam int LANES = WIDTH / LANE_W;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] w_a;
    logic [LANE_W-1:0] w_b;
    logic [LANE_W:0]   w_sum;
    logic [LANE_W:0]   w_dif;

    assign w_a   = i_a[g*LANE_W +: LANE_W];
    assign w_b   = i_b[g*LANE_W +: LANE_W];
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};
    assign w_dif = {1'b0, w_a} - {1'b0, w_b};

    // Bit LANE_W is the carry for add and the borrow for sub; either one means clamp.
    assign o_y[g*LANE_W +: LANE_W] =
      i_sub ? (w_dif[LANE_W] ? '0 : w_dif[LANE_W-1:0])
            : (w_sum[LANE_W] ? '1 : w_sum[LANE_W-1:0]);
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU/PAU result, registered NZCV flags, condition evaluation and enable gating.
module execute_stage
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemPWrite,
  input  logic             RegWrite,
  input  logic             MemWrite,
  input  logic             BranchInst,
  input  logic             ALUSrc,
  input  logic             FlagWrite,
  input  logic             PAUOp,
  input  logic             IOFlag,
  input  logic             ResultSrc,
  input  logic [1:0]       MemToReg,
  input  logic [3:0]       ALUControl,
  input  logic [2:0]       CondFlag,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  input  logic [3:0]       Rd,
  input  logic [WIDTH-1:0] ExtIm,
  output logic             PCSrc,
  output logic             RegWriteOut,
  output logic             MemWriteOut,
  output logic             MemPWriteOut,
  output logic             IOFlagOut,
  output logic [1:0]       MemToRegOut,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] WriteData,
  output logic [3:0]       RdOut
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  flags_t           r_flags;
  flags_t           w_flags_nxt;
  logic [WIDTH-1:0] w_b;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_rsb;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_pau;
  logic             w_alu_c;
  logic             w_alu_v;
  logic             w_cond_ex;

  assign w_b     = ALUSrc ? ExtIm : Rb;
  assign w_shamt = w_b[SHW-1:0];
  // Subtractions are done as add-with-inverted-operand so the carry-out is the no-borrow flag.
  assign w_add   = {1'b0, Ra} + {1'b0, w_b};
  assign w_sub   = {1'b0, Ra} + {1'b0, ~w_b} + ONE;
  assign w_rsb   = {1'b0, w_b} + {1'b0, ~Ra} + ONE;

  always_comb begin
    w_alu   = '0;
    w_alu_c = 1'b0;
    w_alu_v = 1'b0;
    case (alu_op_e'(ALUControl))
      ALU_AND: w_alu = Ra & w_b;
      ALU_ADD: begin
        w_alu   = w_add[WIDTH-1:0];
        w_alu_c = w_add[WIDTH];
        w_alu_v = (Ra[WIDTH-1] == w_b[WIDTH-1]) && (w_add[WIDTH-1] != Ra[WIDTH-1]);
      end
      ALU_SUB: begin
        w_alu   = w_sub[WIDTH-1:0];
        w_alu_c = w_sub[WIDTH];
        w_alu_v = (Ra[WIDTH-1] != w_b[WIDTH-1]) && (w_sub[WIDTH-1] != Ra[WIDTH-1]);
      end
      ALU_ORR: w_alu = Ra | w_b;
      ALU_EOR: w_alu = Ra ^ w_b;
      ALU_LSL: w_alu = Ra << w_shamt;
      ALU_LSR: w_alu = Ra >> w_shamt;
      ALU_ASR: w_alu = $signed(Ra) >>> w_shamt;
      ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(Ra) < $signed(w_b))};
      ALU_MOV: w_alu = w_b;
      ALU_MVN: w_alu = ~w_b;
      ALU_BIC: w_alu = Ra & ~w_b;
      ALU_RSB: begin
        w_alu   = w_rsb[WIDTH-1:0];
        w_alu_c = w_rsb[WIDTH];
        w_alu_v = (w_b[WIDTH-1] != Ra[WIDTH-1]) && (w_rsb[WIDTH-1] != w_b[WIDTH-1]);
      end
      default: w_alu = '0;
    endcase
  end

  exec_pau #(.WIDTH(WIDTH)) u_pau (
    .i_sub (PAUOp),
    .i_a   (Ra),
    .i_b   (w_b),
    .o_y   (w_pau)
  );

  assign ALUResult = ResultSrc ? w_pau : w_alu;

  always_comb begin
    w_flags_nxt.n = ALUResult[WIDTH-1];
    w_flags_nxt.z = (ALUResult == '0);
    w_flags_nxt.c = ResultSrc ? 1'b0 : w_alu_c;
    w_flags_nxt.v = ResultSrc ? 1'b0 : w_alu_v;
  end

  // Condition looks only at flags left by earlier instructions.
  always_comb begin
    w_cond_ex = 1'b1;
    case (cond_e'(CondFlag))
      COND_AL: w_cond_ex = 1'b1;
      COND_EQ: w_cond_ex = r_flags.z;
      COND_NE: w_cond_ex = !r_flags.z;
      COND_GE: w_cond_ex = (r_flags.n == r_flags.v);
      COND_LT: w_cond_ex = (r_flags.n != r_flags.v);
      COND_GT: w_cond_ex = !r_flags.z && (r_flags.n == r_flags.v);
      COND_LE: w_cond_ex = r_flags.z || (r_flags.n != r_flags.v);
      COND_CS: w_cond_ex = r_flags.c;
      default: w_cond_ex = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (FlagWrite && w_cond_ex) begin
      r_flags <= w_flags_nxt;
    end
  end

  assign PCSrc        = BranchInst & w_cond_ex;
  assign RegWriteOut  = RegWrite & w_cond_ex;
  assign MemWriteOut  = MemWrite & w_cond_ex;
  assign MemPWriteOut = MemPWrite & w_cond_ex;
  assign IOFlagOut    = IOFlag & w_cond_ex;
  assign MemToRegOut  = MemToReg;
  assign WriteData    = Rb;
  assign RdOut        = Rd;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: driver pushes hand-computed expectations, monitor pops and compares.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        MemPWrite, RegWrite, MemWrite, BranchInst, ALUSrc, FlagWrite;
  logic        PAUOp, IOFlag, ResultSrc;
  logic [1:0]  MemToReg;
  logic [3:0]  ALUControl;
  logic [2:0]  CondFlag;
  logic [31:0] Ra, Rb, ExtIm;
  logic [3:0]  Rd;
  logic        PCSrc, RegWriteOut, MemWriteOut, MemPWriteOut, IOFlagOut;
  logic [1:0]  MemToRegOut;
  logic [31:0] ALUResult, WriteData;
  logic [3:0]  RdOut;

  int n_checks;
  int n_fails;

  // {pcsrc, {regw,memw,mempw,io}, memtoreg, alu_result, write_data, rd}
  logic [74:0] exp_q[$];
  string       name_q[$];

  execute_stage #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemPWrite    (MemPWrite),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .BranchInst   (BranchInst),
    .ALUSrc       (ALUSrc),
    .FlagWrite    (FlagWrite),
    .PAUOp        (PAUOp),
    .IOFlag       (IOFlag),
    .ResultSrc    (ResultSrc),
    .MemToReg     (MemToReg),
    .ALUControl   (ALUControl),
    .CondFlag     (CondFlag),
    .Ra           (Ra),
    .Rb           (Rb),
    .Rd           (Rd),
    .ExtIm        (ExtIm),
    .PCSrc        (PCSrc),
    .RegWriteOut  (RegWriteOut),
    .MemWriteOut  (MemWriteOut),
    .MemPWriteOut (MemPWriteOut),
    .IOFlagOut    (IOFlagOut),
    .MemToRegOut  (MemToRegOut),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .RdOut        (RdOut)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic clear_inputs();
    rst = 1'b0; MemPWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
    BranchInst = 1'b0; ALUSrc = 1'b0; FlagWrite = 1'b0; PAUOp = 1'b0;
    IOFlag = 1'b0; ResultSrc = 1'b0; MemToReg = 2'b00; ALUControl = 4'h0;
    CondFlag = 3'd0; Ra = '0; Rb = '0; Rd = '0; ExtIm = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic expect_out(input string nm, input logic pc, input logic [3:0] en,
                            input logic [1:0] m2r, input logic [31:0] res,
                            input logic [31:0] wd, input logic [3:0] rd);
    name_q.push_back(nm);
    exp_q.push_back({pc, en, m2r, res, wd, rd});
  endtask

  task automatic branch(input string nm, input logic [2:0] cond, input logic taken);
    step();
    BranchInst = 1'b1;
    CondFlag   = cond;
    expect_out(nm, taken, 4'b0000, 2'b00, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic alu(input string nm, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic fw, input logic [31:0] res);
    step();
    ALUControl = op; Ra = a; Rb = b; FlagWrite = fw;
    expect_out(nm, 1'b0, 4'b0000, 2'b00, res, b, 4'h0);
  endtask

  // scoreboard monitor
  logic [74:0] mon_e;
  string       mon_n;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      n_checks++;
      if ({PCSrc, RegWriteOut, MemWriteOut, MemPWriteOut, IOFlagOut, MemToRegOut} !== mon_e[74:68]) begin
        n_fails++;
        $display("FAIL %s ctrl: got %b expected %b", mon_n,
                 {PCSrc, RegWriteOut, MemWriteOut, MemPWriteOut, IOFlagOut, MemToRegOut}, mon_e[74:68]);
      end
      n_checks++;
      if (ALUResult !== mon_e[67:36]) begin
        n_fails++;
        $display("FAIL %s result: got %h expected %h", mon_n, ALUResult, mon_e[67:36]);
      end
      n_checks++;
      if ({WriteData, RdOut} !== mon_e[35:0]) begin
        n_fails++;
        $display("FAIL %s passthru: got %h/%h expected %h/%h", mon_n, WriteData, RdOut,
                 mon_e[35:4], mon_e[3:0]);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // reset state: NZCV = 0000
    branch("rst_eq", 3'd1, 1'b0);
    branch("rst_ge", 3'd3, 1'b1);
    branch("rst_cs", 3'd7, 1'b0);

    step();
    ALUControl = 4'h1; Ra = 32'd10; Rb = 32'd11; Rd = 4'd10; MemToReg = 2'b01; RegWrite = 1'b1;
    expect_out("add", 1'b0, 4'b1000, 2'b01, 32'd21, 32'd11, 4'd10);

    step();
    ALUControl = 4'h1; ALUSrc = 1'b1; ExtIm = 32'h55; Ra = 32'd1; Rb = 32'h1234;
    expect_out("imm", 1'b0, 4'b0000, 2'b00, 32'h56, 32'h1234, 4'h0);

    // SUB 5-5 -> N0 Z1 C1 V0
    alu("sub_eq", 4'h2, 32'd5, 32'd5, 1'b1, 32'h0);
    branch("br_eq", 3'd1, 1'b1);
    branch("br_ne", 3'd2, 1'b0);
    branch("br_cs", 3'd7, 1'b1);

    // SUB 3-5 -> N1 Z0 C0 V0
    alu("sub_neg", 4'h2, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE);

    // EQ fails: enables gated, and the zero result must not reach the flags
    step();
    CondFlag = 3'd1; RegWrite = 1'b1; MemWrite = 1'b1; MemPWrite = 1'b1; IOFlag = 1'b1;
    FlagWrite = 1'b1;
    expect_out("gate_eq", 1'b0, 4'b0000, 2'b00, 32'h0, 32'h0, 4'h0);
    step();
    CondFlag = 3'd0; RegWrite = 1'b1; MemWrite = 1'b1; MemPWrite = 1'b1; IOFlag = 1'b1;
    expect_out("gate_al", 1'b0, 4'b1111, 2'b00, 32'h0, 32'h0, 4'h0);
    branch("br_lt", 3'd4, 1'b1);
    branch("br_gt", 3'd5, 1'b0);
    branch("br_le", 3'd6, 1'b1);
    branch("br_ne2", 3'd2, 1'b1);

    // signed overflow -> N1 Z0 C0 V1
    alu("add_ovf", 4'h1, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000);
    branch("ovf_ge", 3'd3, 1'b1);
    branch("ovf_cs", 3'd7, 1'b0);

    // unsigned carry -> N0 Z1 C1 V0
    alu("add_cy", 4'h1, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0);
    branch("cy_cs", 3'd7, 1'b1);
    branch("cy_eq", 3'd1, 1'b1);

    // remaining ALU ops
    alu("and", 4'h0, 32'hF0F0, 32'hFF00, 1'b0, 32'hF000);
    alu("orr", 4'h3, 32'hF0F0, 32'hFF00, 1'b0, 32'hFFF0);
    alu("eor", 4'h4, 32'hF0F0, 32'hFF00, 1'b0, 32'h0FF0);
    alu("lsl", 4'h5, 32'h1, 32'h24, 1'b0, 32'h10);
    alu("lsr", 4'h6, 32'h8000_0000, 32'd31, 1'b0, 32'h1);
    alu("asr", 4'h7, 32'h8000_0000, 32'd4, 1'b0, 32'hF800_0000);
    alu("slt1", 4'h8, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h1);
    alu("slt0", 4'h8, 32'h1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    alu("mov", 4'h9, 32'hAAAA, 32'h1234, 1'b0, 32'h1234);
    alu("mvn", 4'hA, 32'hAAAA, 32'h0, 1'b0, 32'hFFFF_FFFF);
    alu("bic", 4'hB, 32'hFF, 32'h0F, 1'b0, 32'hF0);
    alu("rsb", 4'hC, 32'd3, 32'd10, 1'b0, 32'd7);
    alu("op_d", 4'hD, 32'd5, 32'd5, 1'b0, 32'h0);

    // PAU
    step();
    ResultSrc = 1'b1; Ra = 32'hFF10_8001; Rb = 32'h0220_8001; Rd = 4'd3;
    expect_out("pau_add", 1'b0, 4'b0000, 2'b00, 32'hFF30_FF02, 32'h0220_8001, 4'd3);
    step();
    ResultSrc = 1'b1; PAUOp = 1'b1; Ra = 32'h10FF_0005; Rb = 32'h2001_0003;
    expect_out("pau_sub", 1'b0, 4'b0000, 2'b00, 32'h00FE_0002, 32'h2001_0003, 4'h0);

    // PAU result 0 while the ALU add would carry: flags become Z1 C0
    step();
    ResultSrc = 1'b1; PAUOp = 1'b1; ALUControl = 4'h1; FlagWrite = 1'b1;
    Ra = 32'h1; Rb = 32'hFFFF_FFFF;
    expect_out("pau_flag", 1'b0, 4'b0000, 2'b00, 32'h0, 32'hFFFF_FFFF, 4'h0);
    branch("pau_cs", 3'd7, 1'b0);
    branch("pau_eq", 3'd1, 1'b1);

    // reset beats FlagWrite; outputs still follow inputs during reset
    step();
    rst = 1'b1; ALUControl = 4'h2; Ra = 32'd5; Rb = 32'd5; FlagWrite = 1'b1; RegWrite = 1'b1;
    expect_out("in_rst", 1'b0, 4'b1000, 2'b00, 32'h0, 32'h5, 4'h0);
    branch("post_rst_eq", 3'd1, 1'b0);
    branch("post_rst_ge", 3'd3, 1'b1);

    step();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
